// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - shared main-memory arbiter for I-cache fills and D-cache fills/writes
// D side has fixed priority; a granted transaction always runs to its DONE pulse.
module mem_fill_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [15:0]                    d_wdata,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [15:0]                    mem_data_in,
    input  logic [15:0]                    mem_data_out,
    input  logic                           mem_data_valid,
    output logic                           i_fill_valid,
    output logic                           d_fill_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [15:0]                    fill_data,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        I_FILL,
        D_FILL,
        D_WRITE,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  ret_cnt;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;

    logic in_fill, issuing, ret_valid, last_ret;

    assign in_fill   = (state == I_FILL) || (state == D_FILL);
    assign issuing   = in_fill && (issue_cnt < CNT_W'(BLOCK_WORDS));
    // Returns outside a fill state are stale (e.g. after reset) and must be dropped.
    assign ret_valid = in_fill && mem_data_valid;
    assign last_ret  = ret_valid && (ret_cnt == IDX_W'(BLOCK_WORDS - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            owner     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE) begin
                if (d_req) begin
                    owner     <= 1'b1;
                    addr_q    <= d_addr & WORD_MASK;
                    wdata_q   <= d_wdata;
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                end else if (i_req) begin
                    owner     <= 1'b0;
                    addr_q    <= i_addr & WORD_MASK;
                    issue_cnt <= '0;
                    ret_cnt   <= '0;
                end
            end else begin
                if (issuing) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (ret_valid) begin
                    ret_cnt <= ret_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        fill_idx     = '0;
        fill_data    = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && d_wr) begin
                    state_d = D_WRITE;
                end else if (d_req) begin
                    state_d = D_FILL;
                end else if (i_req) begin
                    state_d = I_FILL;
                end
            end
            I_FILL, D_FILL: begin
                if (issuing) begin
                    mem_enable = 1'b1;
                    mem_addr   = (addr_q & BLOCK_MASK) | (ADDR_W'(issue_cnt) << 1);
                end
                if (ret_valid) begin
                    fill_data    = mem_data_out;
                    fill_idx     = ret_cnt;
                    i_fill_valid = ~owner;
                    d_fill_valid = owner;
                end
                if (last_ret) begin
                    state_d = DONE;
                end
            end
            D_WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
                state_d     = DONE;
            end
            DONE: begin
                i_done  = ~owner;
                d_done  = owner;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - self-checking bench for mem_fill_arbiter
// Transaction-level model predicts every output from grant cycle and memory latency.
module tb_mem_fill_arbiter;

    localparam int L  = 4;
    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_data_valid;
    logic        i_fill_valid, d_fill_valid;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done, d_done, busy;

    always #5 clk = ~clk;

    mem_fill_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .fill_idx(fill_idx), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    // Memory: word array plus an L-deep read return pipeline.
    logic [15:0] mem [0:32767];
    logic        rv [L];
    logic [15:0] rd [L];
    logic        iss_pend, stray;
    logic [15:0] iss_data;

    assign mem_data_valid = rv[L-1] | stray;
    assign mem_data_out   = rv[L-1] ? rd[L-1] : (stray ? 16'hDEAD : 16'h0000);

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: one outstanding transaction described by kind and grant cycle.
    bit          m_act;
    int          m_kind;
    int          m_g;
    logic [15:0] m_base, m_waddr, m_wdata;

    int          first_iss_cyc, first_ifill_cyc, i_done_cyc, d_done_cyc, n_ifill, n_dfill;
    logic [15:0] first_iss_addr, last_iss_addr, last_wr_data, d_idx2_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int done_off();
        return (m_kind == 2) ? 2 : BW + 1 + L;
    endfunction

    task automatic clr_log();
        first_iss_cyc = -1; first_ifill_cyc = -1; i_done_cyc = -1; d_done_cyc = -1;
        n_ifill = 0; n_dfill = 0;
        first_iss_addr = 16'h0; last_iss_addr = 16'h0; last_wr_data = 16'h0; d_idx2_data = 16'h0;
    endtask

    // Decide the model's next state from the inputs the coming edge will see.
    task automatic model_update();
        if (rst) begin
            m_act = 0;
        end else if (m_act) begin
            if (cyc - m_g == done_off()) m_act = 0;
        end else if (d_req) begin
            m_act = 1; m_g = cyc; m_kind = d_wr ? 2 : 1;
            m_base = d_addr & 16'hFFF0; m_waddr = d_addr & 16'hFFFE; m_wdata = d_wdata;
        end else if (i_req) begin
            m_act = 1; m_g = cyc; m_kind = 0;
            m_base = i_addr & 16'hFFF0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = L - 1; i > 0; i--) begin
            rv[i] = rv[i-1];
            rd[i] = rd[i-1];
        end
        rv[0] = iss_pend;
        rd[0] = iss_data;
        iss_pend = 1'b0;
    endtask

    task automatic sample();
        logic        e_en, e_wr, e_ifv, e_dfv, e_idone, e_ddone, e_busy;
        logic [15:0] e_addr, e_din, e_fd;
        logic [2:0]  e_idx;
        int          off;
        @(negedge clk);
        e_en = 0; e_wr = 0; e_ifv = 0; e_dfv = 0; e_idone = 0; e_ddone = 0; e_busy = 0;
        e_addr = 0; e_din = 0; e_fd = 0; e_idx = 0;
        if (!rst && m_act) begin
            off    = cyc - m_g;
            e_busy = (off >= 1);
            if (m_kind == 2) begin
                if (off == 1) begin
                    e_en = 1; e_wr = 1; e_addr = m_waddr; e_din = m_wdata;
                end
                if (off == 2) e_ddone = 1;
            end else begin
                if (off >= 1 && off <= BW) begin
                    e_en = 1; e_addr = m_base + 16'(2 * (off - 1));
                end
                if (off >= 1 + L && off <= BW + L) begin
                    e_idx = 3'(off - 1 - L);
                    e_fd  = mem[(m_base >> 1) + 16'(off - 1 - L)];
                    if (m_kind == 0) e_ifv = 1; else e_dfv = 1;
                end
                if (off == BW + 1 + L) begin
                    if (m_kind == 0) e_idone = 1; else e_ddone = 1;
                end
            end
        end
        chk("mem_enable", mem_enable, e_en);
        chk("mem_wr", mem_wr, e_wr);
        chk("busy", busy, e_busy);
        chk("i_fill_valid", i_fill_valid, e_ifv);
        chk("d_fill_valid", d_fill_valid, e_dfv);
        chk("i_done", i_done, e_idone);
        chk("d_done", d_done, e_ddone);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_wr) chk("mem_data_in", mem_data_in, e_din);
        if (e_ifv || e_dfv) begin
            chk("fill_idx", fill_idx, e_idx);
            chk("fill_data", fill_data, e_fd);
        end
        if (mem_enable) begin
            if (first_iss_cyc < 0) begin
                first_iss_cyc = cyc; first_iss_addr = mem_addr;
            end
            last_iss_addr = mem_addr;
            if (mem_wr) begin
                mem[mem_addr[15:1]] = mem_data_in;
                last_wr_data = mem_data_in;
            end else begin
                iss_pend = 1'b1;
                iss_data = mem[mem_addr[15:1]];
            end
        end
        if (i_fill_valid) begin
            n_ifill++;
            if (first_ifill_cyc < 0) first_ifill_cyc = cyc;
        end
        if (d_fill_valid) begin
            n_dfill++;
            if (fill_idx == 3'd2) d_idx2_data = fill_data;
        end
        if (i_done) begin i_done_cyc = cyc; i_req = 1'b0; end
        if (d_done) begin d_done_cyc = cyc; d_req = 1'b0; end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            sample();
        end
    endtask

    int t0;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 7) ^ 16'h3C5A;
        for (int i = 0; i < L; i++) begin rv[i] = 1'b0; rd[i] = 16'h0; end
        iss_pend = 0; iss_data = 0; stray = 0;
        rst = 1; i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        m_act = 0; m_kind = 0; m_g = 0; m_base = 0; m_waddr = 0; m_wdata = 0;
        clr_log();

        run(2);
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_enable", mem_enable, 1'b0);
        tick(); rst = 0; sample();
        run(2);

        // I fill alone at 0x0136
        clr_log(); i_addr = 16'h0136; i_req = 1; t0 = cyc;
        run(16);
        chk("t1_first_issue_cycle", first_iss_cyc - t0, 1);
        chk("t1_first_addr", first_iss_addr, 16'h0130);
        chk("t1_last_addr", last_iss_addr, 16'h013E);
        chk("t1_first_fill_cycle", first_ifill_cyc - t0, 5);
        chk("t1_i_done_cycle", i_done_cyc - t0, 13);
        chk("t1_n_ifill", n_ifill, 8);
        chk("t1_n_dfill", n_dfill, 0);

        // D write then fill of the same block
        clr_log(); d_addr = 16'h2005; d_wdata = 16'hBEEF; d_wr = 1; d_req = 1; t0 = cyc;
        run(4);
        chk("t2_issue_cycle", first_iss_cyc - t0, 1);
        chk("t2_wr_addr", first_iss_addr, 16'h2004);
        chk("t2_wr_data", last_wr_data, 16'hBEEF);
        chk("t2_d_done_cycle", d_done_cyc - t0, 2);
        clr_log(); d_wr = 0; d_addr = 16'h2000; d_req = 1; t0 = cyc;
        run(16);
        chk("t2_fill_idx2", d_idx2_data, 16'hBEEF);
        chk("t2_fill_done", d_done_cyc - t0, 13);

        // Simultaneous requests: D first, I after
        clr_log(); d_addr = 16'h4000; d_req = 1; i_addr = 16'h0500; i_req = 1; t0 = cyc;
        run(30);
        chk("t3_d_done_cycle", d_done_cyc - t0, 13);
        chk("t3_i_done_cycle", i_done_cyc - t0, 27);
        chk("t3_first_ifill", first_ifill_cyc - t0, 19);
        chk("t3_n_ifill", n_ifill, 8);
        chk("t3_n_dfill", n_dfill, 8);

        // I request arriving mid D fill waits
        clr_log(); d_addr = 16'h4010; d_req = 1; t0 = cyc;
        run(3);
        i_addr = 16'h0620; i_req = 1;
        run(27);
        chk("t4_d_done_cycle", d_done_cyc - t0, 13);
        chk("t4_i_done_cycle", i_done_cyc - t0, 27);

        // Reset during fill, then stale returns ignored
        clr_log(); i_addr = 16'h0800; i_req = 1; t0 = cyc;
        run(5);
        tick(); rst = 1; i_req = 0; sample();
        chk("t5_reset_busy", busy, 1'b0);
        chk("t5_reset_enable", mem_enable, 1'b0);
        clr_log();
        tick(); rst = 0; stray = 1; sample();
        run(5);
        stray = 0;
        run(4);
        chk("t5_stale_ifill", n_ifill, 0);
        chk("t5_stale_done", i_done_cyc, -1);
        clr_log(); i_addr = 16'h0A10; i_req = 1; t0 = cyc;
        run(16);
        chk("t5_fresh_done", i_done_cyc - t0, 13);
        chk("t5_fresh_n_ifill", n_ifill, 8);

        // Stray valid in IDLE, then a D fill starts from index 0
        clr_log(); stray = 1;
        run(2);
        stray = 0;
        chk("t6_stray_busy", busy, 1'b0);
        chk("t6_stray_fill", n_ifill + n_dfill, 0);
        d_addr = 16'h0040; d_req = 1; t0 = cyc;
        run(16);
        chk("t6_d_done_cycle", d_done_cyc - t0, 13);
        chk("t6_n_dfill", n_dfill, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares one pipelined, unified main memory between the instruction-cache miss path and the data-cache miss/write path.
- Sequences 8-word block fills on a cache miss and single-word write-through stores.
- Arbitrates between the I-side and D-side requesters and steers returning words to the owner.
- Sits between the two cache controllers and the multi-cycle memory that replaces the two single-cycle memories.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block. Power of two; block = 16 bytes.
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  I-side fill request. Level; held until i_done.
- i_addr  in  ADDR_W  I-side miss byte address.
- d_req  in  1  D-side request. Level; held until d_done.
- d_wr  in  1  1 = single-word write, 0 = block fill.
- d_addr  in  ADDR_W  D-side byte address.
- d_wdata  in  16  D-side store data.
- mem_enable  out  1  memory access issued this cycle.
- mem_wr  out  1  write issue.
- mem_addr  out  ADDR_W  issued address.
- mem_data_in  out  16  write data.
- mem_data_out  in  16  returned read data.
- mem_data_valid  in  1  returned word valid. Arrives a fixed latency after the read issue, in issue order.
- i_fill_valid  out  1  fill word for I-side this cycle.
- d_fill_valid  out  1  fill word for D-side this cycle.
- fill_idx  out  3  word index within block (log2 BLOCK_WORDS).
- fill_data  out  16  fill word.
- i_done  out  1  one-cycle completion pulse, I-side.
- d_done  out  1  one-cycle completion pulse, D-side.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE, DONE. Reset is asynchronous to IDLE.
- Reset values: issue counter 0, return counter 0, owner 0, latched address/data 0. All outputs 0.
- IDLE arbitration is fixed priority, D over I:
  - d_req & d_wr -> D_WRITE.
  - d_req & ~d_wr -> D_FILL.
  - else i_req -> I_FILL.
  - On grant, latch block base = addr & ~(2*BLOCK_WORDS-1) (i.e. addr & 16'hFFF0) and d_wdata. Clear both counters.
- No preemption: a granted transaction always completes. A request arriving mid-transaction waits.
- I_FILL / D_FILL issue phase:
  - mem_enable = 1, mem_wr = 0, mem_addr = base | (issue_cnt << 1), one address per cycle for BLOCK_WORDS consecutive cycles.
  - mem_enable = 0 after issue_cnt reaches BLOCK_WORDS.
- Fill return phase:
  - Each mem_data_valid in a fill state: fill_data = mem_data_out, fill_idx = ret_cnt, owner's *_fill_valid = 1 (combinational from registered state), ret_cnt increments.
  - Issue and return may overlap.
  - On the last word (ret_cnt == BLOCK_WORDS-1 with valid) -> DONE.
- D_WRITE: lasts one cycle. mem_enable = 1, mem_wr = 1, mem_addr = latched d_addr & 16'hFFFE, mem_data_in = latched d_wdata. Then -> DONE.
- DONE: lasts one cycle. Asserts owner's *_done = 1, then -> IDLE. Requests are not sampled in DONE.
  - The requester drops its req by the following edge, so IDLE never regrants a finished request.
- Latency, request first seen in IDLE at cycle 0, memory latency L:
  - Write: issue cycle 1, done cycle 2.
  - Fill: issues cycles 1..8, words cycles 1+L..8+L, done cycle 9+L. With L = 4, done is cycle 13.
- mem_data_valid in IDLE, D_WRITE or DONE is ignored; no fill_valid is produced.
- Reset mid-transaction: everything returns to reset values immediately. Late memory returns after reset are ignored, since the arbiter is in IDLE.
- Simultaneous i_req and d_req: D is served first. I is granted in the IDLE cycle after D's DONE, if still asserted.
- Unaligned addresses: low bits are masked; no error is flagged.

Test Plan:
- I fill alone, i_addr = 0x0136, L = 4:
  - mem_addr 0x0130, 0x0132 .. 0x013E on cycles 1-8.
  - i_fill_valid cycles 5-12 with fill_idx 0-7 and data matching memory.
  - i_done cycle 13 only; d_* signals stay 0.
- D write, d_addr = 0x2005, d_wdata = 0xBEEF:
  - Cycle 1: mem_enable = 1, mem_wr = 1, mem_addr 0x2004, mem_data_in 0xBEEF.
  - Cycle 2: d_done = 1.
  - A later fill of 0x2000 returns 0xBEEF at fill_idx 2.
- i_req and d_req (fill, 0x4000) both rise on cycle 0:
  - D_FILL granted; d_done at cycle 13.
  - I issue starts cycle 15 (IDLE at 14); i_done at cycle 27.
  - No i_fill_valid during D_FILL.
- i_req raised at cycle 3 of a D_FILL: no I issue before the D-side d_done. I granted in the following IDLE.
- rst pulsed at cycle 6 of a fill:
  - Outputs 0 immediately (asynchronous), busy = 0.
  - mem_data_valid pulses on cycles 7-12 produce no fill_valid and no done.
  - A fresh i_req then completes normally.
- Stray mem_data_valid in IDLE: no output change; counters stay 0.
